fp_add32: RTL and testbench

//   IEEE-754 single-precision adder with a registered result. Computes

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_add32_lzc28.sv | 15 +
 rtl/fp_add32.sv | 108 ++++++++++
 tb/tb_fp_add32.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 constants and the unpacked-float type used by the FP datapath.
// Subnormals unpack with a zero mantissa so they behave as signed zero downstream.
package fp_pkg;

  localparam int          FP_EXP_W   = 8;
  localparam int          FP_FRAC_W  = 23;
  localparam int          FP_BIAS    = 127;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W:0]   mant;
  } fp_unpacked_t;

  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign = x[31];
    u.exp  = x[30:23];
    u.mant = (x[30:23] == '0) ? '0 : {1'b1, x[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_add32_lzc28.sv
// Leading-zero counter over the 28-bit adder output; an all-zero input counts 28.
module lzc28 (
  input  logic [27:0] value,
  output logic [4:0]  count
);

  always_comb begin
    count = 5'd28;
    // Later (higher) set bits override earlier ones, leaving the MSB's position.
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_add32.sv
// Binary32 adder, round-to-nearest-even, flush-to-zero, one registered stage.
// Datapath: unpack -> swap/align (G,R,S) -> add/sub -> normalise -> round -> pack.
module fp_add32
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        out_valid,
  output logic [31:0] result
);

  fp_unpacked_t        a_u, b_u, big_u, small_u;
  logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, eff_sub;
  logic [7:0]          exp_diff;
  logic [53:0]         small_shift;
  logic [26:0]         small_al;
  logic [27:0]         sum;
  logic [4:0]          lzc;
  logic [26:0]         norm;
  logic                round_up;
  logic [24:0]         mant_r;
  logic [22:0]         frac;
  logic signed [9:0]   exp_n, exp_f;
  logic [31:0]         sum_next;
  logic                unused_bits;

  assign a_u     = fp_unpack(operand_a);
  assign b_u     = fp_unpack(operand_b);
  assign a_zero  = (a_u.exp == '0);
  assign b_zero  = (b_u.exp == '0);
  assign a_inf   = (a_u.exp == FP_EXP_MAX) && (operand_a[22:0] == '0);
  assign b_inf   = (b_u.exp == FP_EXP_MAX) && (operand_b[22:0] == '0);
  assign a_nan   = (a_u.exp == FP_EXP_MAX) && (operand_a[22:0] != '0);
  assign b_nan   = (b_u.exp == FP_EXP_MAX) && (operand_b[22:0] != '0);
  assign eff_sub = a_u.sign ^ b_u.sign;

  always_comb begin : align_add
    if ({a_u.exp, a_u.mant[22:0]} >= {b_u.exp, b_u.mant[22:0]}) begin
      big_u   = a_u;
      small_u = b_u;
    end else begin
      big_u   = b_u;
      small_u = a_u;
    end
    exp_diff    = big_u.exp - small_u.exp;
    // Bits shifted past the 27-bit window collapse into the sticky position.
    small_shift = {small_u.mant, 30'd0} >> exp_diff;
    if (exp_diff >= 8'd26)
      small_al = {26'd0, |small_u.mant};
    else
      small_al = {small_shift[53:28], small_shift[27] | (|small_shift[26:0])};
    if (eff_sub)
      sum = {1'b0, big_u.mant, 3'b000} - {1'b0, small_al};
    else
      sum = {1'b0, big_u.mant, 3'b000} + {1'b0, small_al};
  end

  lzc28 u_lzc (
    .value (sum),
    .count (lzc)
  );

  always_comb begin : norm_round
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, big_u.exp}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << (lzc - 5'd1);
      exp_n = $signed({2'b00, big_u.exp}) - $signed({5'd0, lzc}) + 10'sd1;
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
    exp_f    = exp_n + $signed({9'd0, mant_r[24]});
    frac     = mant_r[24] ? 23'd0 : mant_r[22:0];

    if (a_nan || b_nan || (a_inf && b_inf && eff_sub))
      sum_next = FP_QNAN;
    else if (a_inf)
      sum_next = operand_a;
    else if (b_inf)
      sum_next = operand_b;
    else if (sum == '0)
      // Only two zeros of sign 1 give -0; exact cancellation is always +0.
      sum_next = {a_zero & b_zero & a_u.sign & b_u.sign, 31'd0};
    else if (exp_f >= 10'sd255)
      sum_next = {big_u.sign, FP_EXP_MAX, 23'd0};
    else if (exp_f <= 10'sd0)
      sum_next = {big_u.sign, 31'd0};
    else
      sum_next = {big_u.sign, exp_f[7:0], frac};
  end

  assign unused_bits = ^{mant_r[23], small_u.sign};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= 32'h0000_0000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) result <= sum_next;
    end
  end

endmodule

// File: tb/tb_fp_add32.sv
// Directed-vector bench for fp_add32: each task drives its scenario and checks inline.
module tb_fp_add32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  fp_add32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid  = v;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    $display("txn v=%0b a=%h b=%h -> out_valid=%0b result=%h", v, a, b, out_valid, result);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; operand_a = 32'h3F80_0000; operand_b = 32'h3F80_0000;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic run_table(input string tag, input logic [31:0] va [], input logic [31:0] vb [],
                           input logic [31:0] vr []);
    for (int i = 0; i < va.size(); i++) begin
      drive(1'b1, va[i], vb[i]);
      total++;
      if (result !== vr[i]) begin
        bad++;
        $display("FAIL %s[%0d]: %h + %h got %h want %h", tag, i, va[i], vb[i], result, vr[i]);
      end
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL %s_valid[%0d]: got %0b want 1", tag, i, out_valid);
      end
    end
  endtask

  task automatic test_arith();
    logic [31:0] va [] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4316_4000};
    logic [31:0] vb [] = '{32'h3F80_0000, 32'hBF80_0000, 32'h3FA0_0000, 32'hBFA0_0000, 32'hC316_0000};
    logic [31:0] vr [] = '{32'h4000_0000, 32'h0000_0000, 32'h4010_0000, 32'hBE80_0000, 32'h3E80_0000};
    run_table("arith", va, vb, vr);
  endtask

  task automatic test_rounding();
    logic [31:0] va [] = '{32'h3F80_0000, 32'h3F80_0001};
    logic [31:0] vb [] = '{32'h3380_0000, 32'h3380_0000};
    logic [31:0] vr [] = '{32'h3F80_0000, 32'h3F80_0002};
    run_table("round", va, vb, vr);
  endtask

  task automatic test_specials();
    logic [31:0] va [] = '{32'h7F80_0000, 32'h7F7F_FFFF, 32'h7FC0_0001, 32'h0000_0000,
                           32'h8000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h0000_0001,
                           32'h0080_0000, 32'hFF80_0000};
    logic [31:0] vb [] = '{32'hFF80_0000, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h8000_0000,
                           32'h8000_0000, 32'h3F80_0001, 32'h3F80_0000, 32'h0000_0000,
                           32'h8080_0001, 32'hFF80_0000};
    logic [31:0] vr [] = '{32'h7FC0_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000,
                           32'h8000_0000, 32'h3F80_0001, 32'h7F80_0000, 32'h0000_0000,
                           32'h8000_0000, 32'hFF80_0000};
    run_table("special", va, vb, vr);
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [] = '{32'h4000_0000, 32'hC000_0000, 32'h3F80_0000};
    logic [31:0] vb [] = '{32'h4000_0000, 32'h3F80_0000, 32'h3F00_0000};
    logic [31:0] vr [] = '{32'h4080_0000, 32'hBF80_0000, 32'h3FC0_0000};
    run_table("b2b", va, vb, vr);
  endtask

  task automatic test_hold();
    drive(1'b1, 32'h3F80_0000, 32'h3FA0_0000);
    drive(1'b0, 32'h4000_0000, 32'h4000_0000);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_valid: got %0b want 0", out_valid); end
    total++;
    if (result !== 32'h4010_0000) begin bad++; $display("FAIL hold_result: got %h want 40100000", result); end
  endtask

  task automatic test_midreset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h3F80_0000, 32'h3F80_0000);
    total++;
    if (result !== 32'h0) begin bad++; $display("FAIL midrst_result: got %h want 00000000", result); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h3F80_0000, 32'h3F80_0000);
    total++;
    if (result !== 32'h4000_0000) begin bad++; $display("FAIL post_rst_result: got %h want 40000000", result); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_hold();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
